fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register feeding the decode stage, where the main controller consumes the opcode and funct fields of the registered instruction. It holds the PC and drives the word address to the external combinational instruction memory. It captures each fetched word and its PC+4 into IF/ID. It applies stall and branch/jump redirect requests returned from decode, including redirects raised while the pipe is stalled.

---
 rtl/mips_pkg.sv | 18 +
 rtl/ifid_register.sv | 20 ++
 rtl/fetch_stage.sv | 77 +++++++
 tb/tb_fetch_stage.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage constants, IF/ID record and fetch FSM encoding.
package mips_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        RUN           = 2'd0,
        STALLED       = 2'd1,
        STALLED_REDIR = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;
endpackage

// File: rtl/ifid_register.sv
// ifid_register: 65-bit IF/ID pipeline register with load, hold and bubble.
module ifid_register
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  bubble,
    input  ifid_t d,
    output ifid_t q
);
    always_ff @(posedge clk) begin
        if (rst || bubble)
            q <= '{instruction: NOP_WORD, pc_plus4: 32'h0, valid: 1'b0};
        else if (load)
            q <= d;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, redirect/stall FSM and IF/ID register feeding decode.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [31:0] TargetPC,
    input  logic [31:0] IMemData,
    output logic [31:0] IMemAddr,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic        AlignFault,
    output logic [31:0] FetchCount
);
    logic [31:0] pc, pend, pc_plus4, tgt;
    logic redir, advance;
    fetch_state_t state, state_next;
    ifid_t ifid_q;

    assign pc_plus4 = pc + 32'd4;
    // A live PCSrc always wins over a target parked during an earlier stall.
    assign tgt = PCSrc ? TargetPC : pend;
    assign redir = !Stall && (PCSrc || state == STALLED_REDIR);
    assign advance = !Stall && !redir;

    always_comb begin
        state_next = !Stall ? RUN :
                     (PCSrc || state == STALLED_REDIR) ? STALLED_REDIR : STALLED;
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= RUN;
        else
            state <= state_next;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc <= RESET_PC;
            pend <= 32'h0;
            AlignFault <= 1'b0;
            FetchCount <= 32'h0;
        end else begin
            if (redir)
                pc <= tgt & ALIGN_MASK;
            else if (advance)
                pc <= pc_plus4;
            if (Stall && PCSrc)
                pend <= TargetPC;
            if ((PCSrc || redir) && tgt[1:0] != 2'b00)
                AlignFault <= 1'b1;
            if (advance)
                FetchCount <= FetchCount + 32'd1;
        end
    end

    ifid_register #(.NOP_WORD(NOP_WORD)) u_ifid (
        .clk(Clk),
        .rst(Reset),
        .load(advance),
        .bubble(redir),
        .d('{instruction: IMemData, pc_plus4: pc_plus4, valid: 1'b1}),
        .q(ifid_q)
    );

    assign IMemAddr = pc;
    assign IFID_Instruction = ifid_q.instruction;
    assign IFID_PCPlus4 = ifid_q.pc_plus4;
    assign IFID_Valid = ifid_q.valid;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven directed checks of fetch_stage plus fault/reset sequences.
module tb_fetch_stage;
    logic        Clk = 1'b0;
    logic        Reset, Stall, PCSrc;
    logic [31:0] TargetPC, IMemData, IMemAddr, IFID_Instruction, IFID_PCPlus4, FetchCount;
    logic        IFID_Valid, AlignFault;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        stall;
        logic        pcsrc;
        logic [31:0] target;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] count;
    } vec_t;

    vec_t v[21];

    fetch_stage dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .PCSrc(PCSrc), .TargetPC(TargetPC),
        .IMemData(IMemData), .IMemAddr(IMemAddr), .IFID_Instruction(IFID_Instruction),
        .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid), .AlignFault(AlignFault),
        .FetchCount(FetchCount)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] m(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign IMemData = m(IMemAddr);

    function automatic vec_t mk(input logic s, input logic p, input logic [31:0] t,
                                input logic [31:0] a, input logic [31:0] i,
                                input logic [31:0] p4, input logic vl, input logic [31:0] c);
        vec_t r;
        r.stall = s; r.pcsrc = p; r.target = t; r.addr = a;
        r.instr = i; r.pc4 = p4; r.valid = vl; r.count = c;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic p, input logic [31:0] t);
        Reset = r; Stall = s; PCSrc = p; TargetPC = t;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] a, input logic [31:0] i,
                           input logic [31:0] p4, input logic vl, input logic f,
                           input logic [31:0] c);
        chk({tag, ".addr"}, IMemAddr, a);
        chk({tag, ".instr"}, IFID_Instruction, i);
        chk({tag, ".pc4"}, IFID_PCPlus4, p4);
        chk({tag, ".valid"}, {31'h0, IFID_Valid}, {31'h0, vl});
        chk({tag, ".fault"}, {31'h0, AlignFault}, {31'h0, f});
        chk({tag, ".count"}, FetchCount, c);
    endtask

    initial begin
        v[0]  = mk(0, 0, 0,      32'h04, m(32'h00), 32'h04, 1, 1);
        v[1]  = mk(0, 0, 0,      32'h08, m(32'h04), 32'h08, 1, 2);
        v[2]  = mk(0, 0, 0,      32'h0C, m(32'h08), 32'h0C, 1, 3);
        v[3]  = mk(0, 0, 0,      32'h10, m(32'h0C), 32'h10, 1, 4);
        v[4]  = mk(0, 1, 32'h40, 32'h40, 32'h0,     32'h0,  0, 4);
        v[5]  = mk(0, 0, 0,      32'h44, m(32'h40), 32'h44, 1, 5);
        v[6]  = mk(0, 1, 32'h1C, 32'h1C, 32'h0,     32'h0,  0, 5);
        v[7]  = mk(0, 0, 0,      32'h20, m(32'h1C), 32'h20, 1, 6);
        v[8]  = mk(1, 0, 0,      32'h20, m(32'h1C), 32'h20, 1, 6);
        v[9]  = mk(1, 0, 0,      32'h20, m(32'h1C), 32'h20, 1, 6);
        v[10] = mk(1, 0, 0,      32'h20, m(32'h1C), 32'h20, 1, 6);
        v[11] = mk(0, 0, 0,      32'h24, m(32'h20), 32'h24, 1, 7);
        v[12] = mk(1, 1, 32'h80, 32'h24, m(32'h20), 32'h24, 1, 7);
        v[13] = mk(1, 1, 32'h90, 32'h24, m(32'h20), 32'h24, 1, 7);
        v[14] = mk(1, 0, 0,      32'h24, m(32'h20), 32'h24, 1, 7);
        v[15] = mk(1, 0, 0,      32'h24, m(32'h20), 32'h24, 1, 7);
        v[16] = mk(0, 0, 0,      32'h90, 32'h0,     32'h0,  0, 7);
        v[17] = mk(0, 0, 0,      32'h94, m(32'h90), 32'h94, 1, 8);
        v[18] = mk(1, 1, 32'hA0, 32'h94, m(32'h90), 32'h94, 1, 8);
        v[19] = mk(0, 1, 32'hB0, 32'hB0, 32'h0,     32'h0,  0, 8);
        v[20] = mk(0, 0, 0,      32'hB4, m(32'hB0), 32'hB4, 1, 9);

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk_all("reset", 32'h0, 32'h0, 32'h0, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            step(0, v[i].stall, v[i].pcsrc, v[i].target);
            chk_all($sformatf("vec%0d", i), v[i].addr, v[i].instr, v[i].pc4, v[i].valid, 0, v[i].count);
        end

        step(0, 0, 1, 32'h103);
        chk_all("misalign", 32'h100, 32'h0, 32'h0, 0, 1, 9);
        step(0, 0, 0, 0);
        chk_all("misalign_next", 32'h104, m(32'h100), 32'h104, 1, 1, 10);
        step(0, 1, 0, 0);
        chk_all("fault_sticky", 32'h104, m(32'h100), 32'h104, 1, 1, 10);

        step(0, 1, 1, 32'h200);
        chk_all("pend200", 32'h104, m(32'h100), 32'h104, 1, 1, 10);
        step(1, 1, 0, 0);
        chk_all("reset_pend", 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_all("after_reset", 32'h04, m(32'h00), 32'h04, 1, 0, 1);
        step(0, 0, 0, 0);
        chk_all("after_reset2", 32'h08, m(32'h04), 32'h08, 1, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
